uart_rx: RTL

UART receiver for the serial link: oversamples `RX_IN` at `Prescale` clocks per bit and tracks each frame with a state machine. The frame is a start bit, `DATA_WIDTH` data bits LSB first, an optional parity bit and one stop bit. It checks the start bit (glitch rejection), parity and stop bit. It delivers the byte on `P_DATA` with a one-cycle `Data_Valid` strobe. It is the receive-side counterpart of the UART transmitter in the same link and sits in the RX clock domain ahead of the data synchronizer.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with one-cycle strobes.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                r_state;
  logic [5:0]            r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [5:0]            r_pre;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_err;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_smp;

  logic [5:0]            w_half;
  logic                  w_last;
  logic                  w_bit;

  assign w_half = {1'b0, r_pre[5:1]};
  assign w_last = (r_edge_cnt == r_pre - 6'd1);

`ifdef UART_RX_MAJORITY_EN
  logic r_smp_lo;
  logic r_smp_hi;

  // Samples either side of the centre; majority masks a one-cycle line glitch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_smp_lo <= 1'b0;
      r_smp    <= 1'b0;
      r_smp_hi <= 1'b0;
    end else if (r_state != IDLE) begin
      if (r_edge_cnt == w_half - 6'd1) r_smp_lo <= RX_IN;
      if (r_edge_cnt == w_half)        r_smp    <= RX_IN;
      if (r_edge_cnt == w_half + 6'd1) r_smp_hi <= RX_IN;
    end
  end

  assign w_bit = (r_smp_lo & r_smp) | (r_smp_lo & r_smp_hi) | (r_smp & r_smp_hi);
`else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                      r_smp <= 1'b0;
    else if (r_state != IDLE && r_edge_cnt == w_half) r_smp <= RX_IN;
  end

  assign w_bit = r_smp;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_pre      <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_err  <= 1'b0;
      r_shift    <= '0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      Par_Err    <= 1'b0;
      Stp_Err    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_edge_cnt <= '0;
          if (!RX_IN) begin
            r_state    <= START;
            r_edge_cnt <= 6'd1;
            r_pre      <= Prescale;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_err  <= 1'b0;
          end
        end
        default: begin
          r_edge_cnt <= w_last ? 6'd0 : r_edge_cnt + 6'd1;
          if (w_last) begin
            case (r_state)
              START: begin
                r_bit_cnt <= '0;
                r_state   <= w_bit ? IDLE : DATA;
              end
              DATA: begin
                r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
                  r_bit_cnt <= '0;
                  r_state   <= r_par_en ? PARITY : STOP;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                end
              end
              PARITY: begin
                r_par_err <= ((^r_shift) ^ r_par_typ) != w_bit;
                r_state   <= STOP;
              end
              STOP: begin
                Par_Err    <= r_par_err;
                Stp_Err    <= ~w_bit;
                Data_Valid <= ~r_par_err & w_bit;
                if (~r_par_err & w_bit) P_DATA <= r_shift;
                // An early falling line here is edge 0 of the next frame.
                if (!RX_IN) begin
                  r_state    <= START;
                  r_edge_cnt <= 6'd1;
                  r_pre      <= Prescale;
                  r_par_en   <= PAR_EN;
                  r_par_typ  <= PAR_TYP;
                  r_par_err  <= 1'b0;
                end else begin
                  r_state <= IDLE;
                end
              end
              default: r_state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
